// File: rtl/i2cmb_wb_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// i2cmb_wb_sequencer
//
// Wishbone master that drives the CSR/DPR/CMDR register port of an iicmb_m_wb
// I2C controller. It turns byte-level transfer requests (slave address,
// direction, length, write-data stream) into the controller command sequence:
// enable, set bus, start, address, write/read bytes, stop. Each controller
// command is written to CMDR, the controller interrupt is awaited, and CMDR is
// read back to obtain the completion status.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*                 transfer request (valid/ready), addr, rw, len
//   wdata_*               write byte stream (valid/ready)
//   rdata, rdata_valid,   read byte stream, one-cycle pulse per byte,
//   rdata_last            last flag on the final byte
//   done_o, err_code      end-of-transfer pulse and status
//                         (0 ok, 1 NAK, 2 arbitration lost / error, 3 timeout)
//   init_done             controller enabled and bus selected
//   cyc_o, stb_o, we_o,   Wishbone master side
//   adr_o, dat_o, dat_i,
//   ack_i
//   irq_i                 controller interrupt (level)
//
// Handshakes: on req_* and wdata_* a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds its data stable
// while valid is high until that edge. req_ready is high only in IDLE;
// wdata_ready is a one-cycle pulse during which the byte is captured.
// -----------------------------------------------------------------------------
module i2cmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int BUS_ID         = 5,
  parameter int IRQ_TIMEOUT    = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // transfer request
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_rw,
  input  logic [7:0]                req_len,
  // write data stream
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [WB_DATA_WIDTH-1:0]  wdata,
  // read data stream
  output logic                      rdata_valid,
  output logic [WB_DATA_WIDTH-1:0]  rdata,
  output logic                      rdata_last,
  // status
  output logic                      done_o,
  output logic [1:0]                err_code,
  output logic                      init_done,
  // Wishbone master
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  // Controller register map
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

  // Controller commands
  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_RD_ACK  = 8'h02;
  localparam logic [7:0] CMD_RD_NAK  = 8'h03;
  localparam logic [7:0] CMD_START   = 8'h04;
  localparam logic [7:0] CMD_STOP    = 8'h05;
  localparam logic [7:0] CMD_SET_BUS = 8'h06;

  // CSR enable: core enable + interrupt enable
  localparam logic [7:0] CSR_ENABLE = 8'hC0;

  localparam logic [15:0] TMO_LAST = 16'(IRQ_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_INIT_CSR,   // write CSR enable
    S_INIT_DPR,   // write bus id to DPR
    S_INIT_WAIT,  // back-off before retrying a failed init
    S_IDLE,       // accepting requests
    S_ADDR_DPR,   // write {addr,rw} to DPR
    S_WR_WAIT,    // fetch next write byte from the stream
    S_WR_DPR,     // write data byte to DPR
    S_RD_DPR,     // read received byte from DPR
    S_CMD_WR,     // command primitive: write CMDR
    S_CMD_IRQ,    // command primitive: wait for irq_i
    S_CMD_RD,     // command primitive: read CMDR status
    S_DONE        // end-of-transfer pulse
  } state_t;

  // Which phase issued the command currently in the CMD primitive; decides
  // where the status read-back leads.
  typedef enum logic [2:0] {
    C_INIT,
    C_START,
    C_ADDR,
    C_WR,
    C_RD,
    C_STOP
  } ctx_t;

  state_t                      state;
  ctx_t                        ctx;
  logic [7:0]                  cmd_q;
  logic [I2C_ADDR_WIDTH-1:0]   addr_q;
  logic                        rw_q;
  logic [7:0]                  len_q;
  logic [7:0]                  byte_cnt;
  logic [15:0]                 tmo_cnt;
  logic [3:0]                  idle_cnt;
  logic [WB_DATA_WIDTH-1:0]    wbyte_q;
  logic [1:0]                  xfer_err;
  logic                        to_init;

  // Bus access wanted by the current state
  logic                        acc_req;
  logic                        acc_we;
  logic [WB_ADDR_WIDTH-1:0]    acc_adr;
  logic [WB_DATA_WIDTH-1:0]    acc_dat;
  logic                        wb_done;
  logic [1:0]                  st_code;
  logic                        is_last;
  logic                        next_is_last;

  always_comb begin
    acc_req = 1'b0;
    acc_we  = 1'b0;
    acc_adr = ADR_CSR;
    acc_dat = '0;
    case (state)
      S_INIT_CSR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CSR;
        acc_dat = WB_DATA_WIDTH'(CSR_ENABLE);
      end
      S_INIT_DPR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_DPR;
        acc_dat = WB_DATA_WIDTH'(BUS_ID);
      end
      S_ADDR_DPR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_DPR;
        acc_dat = WB_DATA_WIDTH'({addr_q, rw_q});
      end
      S_WR_DPR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_DPR;
        acc_dat = wbyte_q;
      end
      S_RD_DPR: begin
        acc_req = 1'b1; acc_we = 1'b0; acc_adr = ADR_DPR;
      end
      S_CMD_WR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CMDR;
        acc_dat = WB_DATA_WIDTH'(cmd_q);
      end
      S_CMD_RD: begin
        acc_req = 1'b1; acc_we = 1'b0; acc_adr = ADR_CMDR;
      end
      default: ;
    endcase
  end

  assign wb_done = cyc_o & ack_i;

  // Status priority: DON, then NAK, then AL/ERR. A status with no completion
  // bit set at all is treated as an error as well.
  always_comb begin
    if (dat_i[7])      st_code = 2'd0;
    else if (dat_i[6]) st_code = 2'd1;
    else               st_code = 2'd2;
  end

  // byte_cnt is the index of the byte being handled; 9-bit compare so that
  // len = 255 cannot wrap.
  assign is_last      = ({1'b0, byte_cnt} + 9'd1) == {1'b0, len_q};
  assign next_is_last = ({1'b0, byte_cnt} + 9'd2) == {1'b0, len_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_INIT_CSR;
      ctx         <= C_INIT;
      cmd_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      len_q       <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      idle_cnt    <= '0;
      wbyte_q     <= '0;
      xfer_err    <= '0;
      to_init     <= 1'b0;
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_last  <= 1'b0;
      done_o      <= 1'b0;
      err_code    <= '0;
      init_done   <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
    end else begin
      done_o      <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      wdata_ready <= 1'b0;

      // Bus engine. A cycle is launched only while cyc_o is low, and the state
      // advances on the ack edge, so cyc_o is always low for at least one
      // cycle between two accesses.
      if (acc_req && !cyc_o) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= acc_we;
        adr_o <= acc_adr;
        dat_o <= acc_dat;
      end else if (wb_done) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        we_o  <= 1'b0;
      end

      case (state)
        S_INIT_CSR: begin
          if (wb_done) state <= S_INIT_DPR;
        end

        S_INIT_DPR: begin
          if (wb_done) begin
            cmd_q <= CMD_SET_BUS;
            ctx   <= C_INIT;
            state <= S_CMD_WR;
          end
        end

        S_INIT_WAIT: begin
          if (idle_cnt == 4'd15) begin
            idle_cnt <= '0;
            state    <= S_INIT_CSR;
          end else begin
            idle_cnt <= idle_cnt + 4'd1;
          end
        end

        S_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            rw_q      <= req_rw;
            len_q     <= req_len;
            byte_cnt  <= '0;
            xfer_err  <= '0;
            err_code  <= '0;
            req_ready <= 1'b0;
            cmd_q     <= CMD_START;
            ctx       <= C_START;
            state     <= S_CMD_WR;
          end
        end

        S_ADDR_DPR: begin
          if (wb_done) begin
            cmd_q <= CMD_WRITE;
            ctx   <= C_ADDR;
            state <= S_CMD_WR;
          end
        end

        S_WR_WAIT: begin
          // Raise ready once valid is seen; the byte is taken on the edge that
          // ends the ready cycle. If valid was withdrawn, ask again.
          if (wdata_ready) begin
            if (wdata_valid) begin
              wbyte_q <= wdata;
              state   <= S_WR_DPR;
            end
          end else if (wdata_valid) begin
            wdata_ready <= 1'b1;
          end
        end

        S_WR_DPR: begin
          if (wb_done) begin
            cmd_q <= CMD_WRITE;
            ctx   <= C_WR;
            state <= S_CMD_WR;
          end
        end

        S_RD_DPR: begin
          if (wb_done) begin
            rdata       <= dat_i;
            rdata_valid <= 1'b1;
            rdata_last  <= is_last;
            byte_cnt    <= byte_cnt + 8'd1;
            if (is_last) begin
              cmd_q <= CMD_STOP;
              ctx   <= C_STOP;
            end else begin
              cmd_q <= next_is_last ? CMD_RD_NAK : CMD_RD_ACK;
              ctx   <= C_RD;
            end
            state <= S_CMD_WR;
          end
        end

        S_CMD_WR: begin
          if (wb_done) begin
            tmo_cnt <= '0;
            state   <= S_CMD_IRQ;
          end
        end

        S_CMD_IRQ: begin
          if (irq_i) begin
            state <= S_CMD_RD;
          end else if (tmo_cnt == TMO_LAST) begin
            // The controller is presumed wedged: no STOP, re-enable it.
            tmo_cnt <= '0;
            if (ctx == C_INIT) begin
              idle_cnt <= '0;
              state    <= S_INIT_WAIT;
            end else begin
              err_code <= 2'd3;
              done_o   <= 1'b1;
              to_init  <= 1'b1;
              state    <= S_DONE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_CMD_RD: begin
          if (wb_done) begin
            case (ctx)
              C_INIT: begin
                if (st_code == 2'd0) begin
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
                end else begin
                  idle_cnt <= '0;
                  state    <= S_INIT_WAIT;
                end
              end
              C_START: begin
                if (st_code == 2'd0) begin
                  state <= S_ADDR_DPR;
                end else begin
                  // START never took the bus, so there is nothing to STOP.
                  err_code <= st_code;
                  done_o   <= 1'b1;
                  state    <= S_DONE;
                end
              end
              C_ADDR: begin
                if (st_code != 2'd0) begin
                  xfer_err <= st_code;
                  cmd_q    <= CMD_STOP;
                  ctx      <= C_STOP;
                  state    <= S_CMD_WR;
                end else if (len_q == 8'd0) begin
                  cmd_q <= CMD_STOP;
                  ctx   <= C_STOP;
                  state <= S_CMD_WR;
                end else if (rw_q) begin
                  cmd_q <= (len_q == 8'd1) ? CMD_RD_NAK : CMD_RD_ACK;
                  ctx   <= C_RD;
                  state <= S_CMD_WR;
                end else begin
                  state <= S_WR_WAIT;
                end
              end
              C_WR: begin
                if (st_code != 2'd0) begin
                  xfer_err <= st_code;
                  cmd_q    <= CMD_STOP;
                  ctx      <= C_STOP;
                  state    <= S_CMD_WR;
                end else begin
                  byte_cnt <= byte_cnt + 8'd1;
                  if (is_last) begin
                    cmd_q <= CMD_STOP;
                    ctx   <= C_STOP;
                    state <= S_CMD_WR;
                  end else begin
                    state <= S_WR_WAIT;
                  end
                end
              end
              C_RD: begin
                if (st_code != 2'd0) begin
                  xfer_err <= st_code;
                  cmd_q    <= CMD_STOP;
                  ctx      <= C_STOP;
                  state    <= S_CMD_WR;
                end else begin
                  state <= S_RD_DPR;
                end
              end
              default: begin
                // STOP finished: report the first error seen in the transfer,
                // otherwise the status of the STOP itself.
                err_code <= (xfer_err != 2'd0) ? xfer_err : st_code;
                done_o   <= 1'b1;
                state    <= S_DONE;
              end
            endcase
          end
        end

        S_DONE: begin
          if (to_init) begin
            to_init <= 1'b0;
            state   <= S_INIT_CSR;
          end else begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_INIT_CSR;
      endcase
    end
  end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_i2cmb_wb_sequencer
//
// Bench for i2cmb_wb_sequencer. A behavioural iicmb controller model answers
// the Wishbone port (random ack latency, random irq latency, scripted status),
// a write-stream driver feeds bytes, and a reference model built from the
// transfer rules queues the expected Wishbone transactions and read bytes.
// -----------------------------------------------------------------------------
module tb_i2cmb_wb_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = '0;
  logic       req_rw = 1'b0;
  logic [7:0] req_len = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [7:0] wdata = '0;
  logic       rdata_valid;
  logic [7:0] rdata;
  logic       rdata_last;
  logic       done_o;
  logic [1:0] err_code;
  logic       init_done;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = '0;
  logic       ack_i = 1'b0;
  logic       irq_i = 1'b0;

  i2cmb_wb_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .done_o(done_o), .err_code(err_code), .init_done(init_done),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;

  logic [10:0] exp_q[$];     // {we, adr, data} of each expected WB transaction
  logic [8:0]  rd_exp_q[$];  // {last, byte} of each expected read byte
  logic [7:0]  wq[$];        // write stream waiting for the DUT
  logic [7:0]  rd_src_q[$];  // bytes the controller model returns from DPR

  logic [7:0] tx_bytes[256];
  logic [7:0] rx_bytes[256];

  bit sb_on = 1'b1;
  bit nak_addr = 1'b0;
  bit hang_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- controller model (Wishbone slave) ----------------
  int         ack_wait = 0;
  bit         irq_armed = 1'b0;
  int         irq_cnt = 0;
  bit         after_start = 1'b0;
  logic [7:0] cur_status = 8'h80;
  logic [7:0] sl_d;
  logic [10:0] sl_e;

  always @(negedge clk) begin
    if (rst) begin
      ack_i = 1'b0; irq_i = 1'b0; irq_armed = 1'b0;
      after_start = 1'b0; ack_wait = 0;
    end else begin
      if (irq_armed) begin
        if (irq_cnt == 0) begin irq_i = 1'b1; irq_armed = 1'b0; end
        else irq_cnt--;
      end
      if (ack_i) begin
        ack_i = 1'b0;
      end else if (cyc_o && stb_o) begin
        if (ack_wait != 0) begin
          ack_wait--;
        end else begin
          sl_d = dat_o;
          if (!we_o) begin
            if (adr_o == 2'd2) begin
              sl_d = cur_status;
              irq_i = 1'b0;
            end else if (adr_o == 2'd1) begin
              if (rd_src_q.size() != 0) sl_d = rd_src_q.pop_front();
              else sl_d = 8'hEE;
            end else begin
              sl_d = 8'h00;
            end
            dat_i = sl_d;
          end else if (adr_o == 2'd2) begin
            cur_status = 8'h80;
            if (dat_o == 8'h04) begin
              after_start = 1'b1;
              if (!hang_start) begin irq_armed = 1'b1; irq_cnt = $urandom_range(0, 4); end
            end else begin
              if (dat_o == 8'h01 && after_start && nak_addr) cur_status = 8'h40;
              after_start = 1'b0;
              irq_armed = 1'b1;
              irq_cnt = $urandom_range(0, 4);
            end
          end
          if (sb_on) begin
            check("wb_txn_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              sl_e = exp_q.pop_front();
              check("wb_txn", {we_o, adr_o, sl_d}, sl_e);
            end
          end
          ack_i = 1'b1;
          ack_wait = $urandom_range(0, 2);
        end
      end
    end
  end

  // ---------------- write-stream driver ----------------
  bit wr_take = 1'b0;
  int bytes_taken = 0;

  always @(negedge clk) begin
    if (rst) begin
      wdata_valid = 1'b0;
      wr_take = 1'b0;
    end else begin
      if (wr_take) begin
        if (wq.size() != 0) void'(wq.pop_front());
        bytes_taken++;
        wr_take = 1'b0;
      end
      wdata_valid = (wq.size() != 0);
      wdata = (wq.size() != 0) ? wq[0] : 8'h00;
      wr_take = wdata_valid && wdata_ready;
    end
  end

  // ---------------- read-stream monitor ----------------
  logic [8:0] rd_e;
  always @(negedge clk) begin
    if (!rst && rdata_valid) begin
      check("rdata_expected", rd_exp_q.size() != 0, 1);
      if (rd_exp_q.size() != 0) begin
        rd_e = rd_exp_q.pop_front();
        check("rdata", {rdata_last, rdata}, rd_e);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_rd(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask

  task automatic exp_cmd(input logic [7:0] c, input logic [7:0] status);
    push_wr(2'd2, c);
    push_rd(2'd2, status);
  endtask

  task automatic exp_init();
    push_wr(2'd0, 8'hC0);
    push_wr(2'd1, 8'h05);
    exp_cmd(8'h06, 8'h80);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [6:0] a, input logic rw, input logic [7:0] len);
    int n = 0;
    req_addr = a; req_rw = rw; req_len = len; req_valid = 1'b1;
    while (!req_ready && n < 5000) begin @(negedge clk); n++; end
    check("req_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_not_ready", req_ready, 0);
  endtask

  task automatic wait_done(input int limit, output bit got, output logic [1:0] err);
    int n = 0;
    got = 1'b0; err = 2'd0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (done_o) begin got = 1'b1; err = err_code; break; end
    end
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int n = 0;
    while (!req_ready && n < limit) begin @(negedge clk); n++; end
    check(tag, req_ready, 1);
  endtask

  task automatic run_xfer(input logic [6:0] a, input logic rw, input logic [7:0] len,
                          input bit nak);
    bit got;
    logic [1:0] err;
    logic [1:0] exp_err;
    exp_err = nak ? 2'd1 : 2'd0;
    for (int i = 0; i < int'(len); i++) begin
      if (!rw) wq.push_back(tx_bytes[i]);
      else rd_src_q.push_back(rx_bytes[i]);
    end
    exp_cmd(8'h04, 8'h80);
    push_wr(2'd1, {a, rw});
    if (nak) begin
      exp_cmd(8'h01, 8'h40);
    end else begin
      exp_cmd(8'h01, 8'h80);
      for (int i = 0; i < int'(len); i++) begin
        if (!rw) begin
          push_wr(2'd1, tx_bytes[i]);
          exp_cmd(8'h01, 8'h80);
        end else begin
          exp_cmd((i == int'(len) - 1) ? 8'h03 : 8'h02, 8'h80);
          push_rd(2'd1, rx_bytes[i]);
          rd_exp_q.push_back({(i == int'(len) - 1), rx_bytes[i]});
        end
      end
    end
    exp_cmd(8'h05, 8'h80);
    do_req(a, rw, len);
    wait_done(20000, got, err);
    check("done_seen", got, 1);
    check("err_code", err, exp_err);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    wait_ready(2000, "ready_after_done");
    check("err_held", err_code, exp_err);
    check("wb_drained", exp_q.size(), 0);
    check("rd_drained", rd_exp_q.size(), 0);
    wq.delete();
    rd_src_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    logic [1:0] err;
    int n;
    int t0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rdata", {rdata_valid, rdata_last, rdata}, 0);
    check("rst_done_err", {done_o, err_code}, 0);
    check("rst_init_done", init_done, 0);
    check("rst_wdata_ready", wdata_ready, 0);

    // init sequence
    exp_init();
    rst = 1'b0;
    wait_ready(1000, "init_ready");
    check("init_done", init_done, 1);
    check("init_wb_drained", exp_q.size(), 0);

    // write 32 bytes 0x00..0x1F to 0x69
    for (int i = 0; i < 32; i++) tx_bytes[i] = 8'(i);
    run_xfer(7'h69, 1'b0, 8'd32, 1'b0);

    // read 4 bytes A0..A3 from 0x69
    for (int i = 0; i < 4; i++) rx_bytes[i] = 8'hA0 + 8'(i);
    run_xfer(7'h69, 1'b1, 8'd4, 1'b0);

    // address NAK on a write of length 8
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom);
    nak_addr = 1'b1;
    run_xfer(7'h69, 1'b0, 8'd8, 1'b1);
    nak_addr = 1'b0;

    // address-only transfers and random traffic
    run_xfer(7'h12, 1'b0, 8'd0, 1'b0);
    run_xfer(7'h34, 1'b1, 8'd1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic [6:0] a;
      logic       rw;
      logic [7:0] len;
      a = 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      len = 8'($urandom_range(0, 5));
      for (int i = 0; i < 6; i++) begin
        tx_bytes[i] = 8'($urandom);
        rx_bytes[i] = 8'($urandom);
      end
      run_xfer(a, rw, len, 1'b0);
    end

    // irq never arrives after START: timeout, no STOP, init replayed
    hang_start = 1'b1;
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    push_wr(2'd2, 8'h04);
    exp_init();
    do_req(7'h55, 1'b0, 8'd2);
    wait_done(70000, got, err);
    check("tmo_done_seen", got, 1);
    check("tmo_err_code", err, 3);
    hang_start = 1'b0;
    wait_ready(2000, "tmo_reinit_ready");
    check("tmo_err_held", err_code, 3);
    check("tmo_init_done", init_done, 1);
    check("tmo_wb_drained", exp_q.size(), 0);
    wq.delete();

    // reset during a 32-byte write once 10 bytes are in
    sb_on = 1'b0;
    for (int i = 0; i < 32; i++) wq.push_back(8'($urandom));
    t0 = bytes_taken;
    do_req(7'h69, 1'b0, 8'd32);
    n = 0;
    while ((bytes_taken - t0) < 10 && n < 5000) begin @(negedge clk); n++; end
    check("mid_write_reached", (bytes_taken - t0) >= 10, 1);
    n = 0;
    while (!cyc_o && n < 100) begin @(negedge clk); n++; end
    check("mid_write_cyc_active", cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc", cyc_o, 0);
    check("async_rst_stb", stb_o, 0);
    check("async_rst_init_done", init_done, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    wq.delete();
    rd_exp_q.delete();
    rd_src_q.delete();
    sb_on = 1'b1;
    exp_init();
    rst = 1'b0;
    // request raised before init completes must wait for the init sequence
    for (int i = 0; i < 5; i++) tx_bytes[i] = 8'($urandom);
    run_xfer(7'h2A, 1'b0, 8'd5, 1'b0);
    check("post_rst_init_done", init_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute guard against a stuck run
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
